// File: rtl/timer_scheduler.sv
// timer_scheduler: plays back a small table of interval lengths into the Timer block.
// For each slot it issues a one-cycle start with a stable interval value, then waits
// for the timer's end pulse before launching the next slot. It supports one-shot and
// looping playback and abort, and flags zero intervals and out-of-range lengths.

module timer_scheduler #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [W-1:0]  cfg_data_i,
  input  logic [AW:0]   cfg_len_i,
  input  logic          loop_i,
  input  logic          run_i,
  input  logic          abort_i,
  input  logic          timer_end_i,
  output logic          timer_start_o,
  output logic [W-1:0]  timer_n_o,
  output logic [AW-1:0] slot_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] SLOT_ZERO = AW'(0);
  localparam logic [AW-1:0] SLOT_ONE  = AW'(1);
  localparam logic [W-1:0]  N_ZERO    = W'(0);

  // Next slot index, wrapping modulo DEPTH.
  function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] s);
    return s + SLOT_ONE;
  endfunction

  // True when slot s is the final active slot of a sequence of length len.
  // Compared at AW+1 bits so that len == DEPTH works without overflow.
  function automatic logic is_last_slot(input logic [AW-1:0] s, input logic [AW:0] len);
    return (({1'b0, s} + LEN_ONE) == len);
  endfunction

  // A sequence length is usable only when it is between 1 and DEPTH.
  function automatic logic len_valid(input logic [AW:0] len);
    return (len != LEN_ZERO) && (len <= LEN_MAX);
  endfunction

  logic [W-1:0]  slot_tbl_r [DEPTH];
  state_t        state_r;
  logic [AW:0]   len_r;

  logic          launch_req_s;
  logic [AW-1:0] launch_slot_s;
  logic [W-1:0]  launch_val_s;
  logic          launch_zero_s;
  logic          run_accept_s;
  logic          run_bad_s;
  logic          go_idle_s;
  logic          done_set_s;
  logic          to_abort_s;

  // Interval table: writable at any time; a launch reads the value held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_tbl_r[i] <= N_ZERO;
      end
    end else if (cfg_we_i) begin
      slot_tbl_r[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Next-action decode: decides whether this edge launches a slot, returns to idle or aborts.
  always_comb begin
    launch_req_s  = 1'b0;
    launch_slot_s = SLOT_ZERO;
    run_accept_s  = 1'b0;
    run_bad_s     = 1'b0;
    go_idle_s     = 1'b0;
    done_set_s    = 1'b0;
    to_abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run_i) begin
          run_accept_s = 1'b1;
          if (len_valid(cfg_len_i)) begin
            launch_req_s  = 1'b1;
            launch_slot_s = SLOT_ZERO;
          end else begin
            run_bad_s = 1'b1;
          end
        end else begin
          run_accept_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (timer_end_i && abort_i) begin
          // Abort wins over the end pulse: no done, no further launch.
          go_idle_s = 1'b1;
        end else if (timer_end_i) begin
          if (!is_last_slot(slot_o, len_r)) begin
            launch_req_s  = 1'b1;
            launch_slot_s = next_slot(slot_o);
          end else if (loop_i) begin
            launch_req_s  = 1'b1;
            launch_slot_s = SLOT_ZERO;
          end else begin
            go_idle_s  = 1'b1;
            done_set_s = 1'b1;
          end
        end else if (abort_i) begin
          to_abort_s = 1'b1;
        end else begin
          go_idle_s = 1'b0;
        end
      end
      ST_ABORT: begin
        // The timer cannot be stopped, so the interval is waited out.
        if (timer_end_i) begin
          go_idle_s = 1'b1;
        end else begin
          go_idle_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  assign launch_val_s  = slot_tbl_r[launch_slot_s];
  assign launch_zero_s = (launch_val_s == N_ZERO);

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      len_r         <= LEN_ZERO;
      timer_start_o <= 1'b0;
      timer_n_o     <= N_ZERO;
      slot_o        <= SLOT_ZERO;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      timer_start_o <= 1'b0;
      done_o        <= 1'b0;

      if (run_accept_s) begin
        len_r <= cfg_len_i;
        err_o <= run_bad_s;
      end

      if (launch_req_s) begin
        if (launch_zero_s) begin
          // A zero interval would make the timer run its full 2^W range; refuse it.
          err_o   <= 1'b1;
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end else begin
          slot_o        <= launch_slot_s;
          timer_n_o     <= launch_val_s;
          timer_start_o <= 1'b1;
          state_r       <= ST_WAIT;
          busy_o        <= 1'b1;
        end
      end else if (go_idle_s) begin
        state_r <= ST_IDLE;
        busy_o  <= 1'b0;
        done_o  <= done_set_s;
      end else if (to_abort_s) begin
        state_r <= ST_ABORT;
      end
    end
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: a behavioural model of the sequencing rules is compared
// against the DUT every cycle, directed scenarios pin the model with literal timings,
// and a randomized phase exercises writes, runs, loops and aborts together.

module tb_timer_scheduler;
  localparam int DEPTH = 4;
  localparam int W     = 16;
  localparam int AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [W-1:0]  cfg_data_i;
  logic [AW:0]   cfg_len_i;
  logic          loop_i;
  logic          run_i;
  logic          abort_i;
  logic          timer_end_i;
  logic          timer_start_o;
  logic [W-1:0]  timer_n_o;
  logic [AW-1:0] slot_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  timer_scheduler #(.DEPTH(DEPTH), .W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_len_i(cfg_len_i), .loop_i(loop_i), .run_i(run_i), .abort_i(abort_i),
    .timer_end_i(timer_end_i), .timer_start_o(timer_start_o), .timer_n_o(timer_n_o),
    .slot_o(slot_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // behavioural model
  bit m_play, m_abort, m_start, m_done, m_err;
  int m_slot, m_n, m_len;
  int m_tab [DEPTH];

  // timer environment and event log (cycles relative to the run cycle t0)
  int end_at = -1;
  int t0 = 0;
  int st_rel[$];
  int st_n[$];
  int st_slot[$];
  int done_rel = -1;
  int err_rel = -1;
  bit busy_at [64];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  function automatic void model_reset();
    m_play = 0; m_abort = 0; m_start = 0; m_done = 0; m_err = 0;
    m_slot = 0; m_n = 0; m_len = 0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
  endfunction

  function automatic void model_launch(input int s);
    if (m_tab[s] == 0) begin
      m_err = 1; m_play = 0; m_abort = 0;
    end else begin
      m_slot = s; m_n = m_tab[s]; m_start = 1; m_play = 1; m_abort = 0;
    end
  endfunction

  // One clock edge of the sequencing rules, using the inputs as they stand.
  function automatic void model_step();
    m_start = 0;
    m_done  = 0;
    if (!m_play) begin
      if (run_i) begin
        m_len = int'(cfg_len_i);
        m_err = 0;
        if (m_len < 1 || m_len > DEPTH) m_err = 1;
        else model_launch(0);
      end
    end else if (m_abort) begin
      if (timer_end_i) begin m_play = 0; m_abort = 0; end
    end else if (timer_end_i) begin
      if (abort_i) m_play = 0;
      else if (m_slot < m_len - 1) model_launch((m_slot + 1) % DEPTH);
      else if (loop_i) model_launch(0);
      else begin m_play = 0; m_done = 1; end
    end else if (abort_i) begin
      m_abort = 1;
    end
    if (cfg_we_i) m_tab[int'(cfg_addr_i)] = int'(cfg_data_i);
  endfunction

  task automatic tick();
    int rel;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    chk("start", 32'(timer_start_o), 32'(m_start));
    chk("n",     32'(timer_n_o),     32'(m_n));
    chk("slot",  32'(slot_o),        32'(m_slot));
    chk("busy",  32'(busy_o),        32'(m_play));
    chk("done",  32'(done_o),        32'(m_done));
    chk("err",   32'(err_o),         32'(m_err));
    rel = cyc - t0;
    if (timer_start_o) begin
      st_rel.push_back(rel);
      st_n.push_back(int'(timer_n_o));
      st_slot.push_back(int'(slot_o));
      end_at = cyc + int'(timer_n_o) + 1;
    end
    if (done_o) done_rel = rel;
    if (err_o && err_rel < 0) err_rel = rel;
    if (rel >= 0 && rel < 64) busy_at[rel] = busy_o;
    timer_end_i = (cyc == end_at);
    run_i    = 1'b0;
    abort_i  = 1'b0;
    cfg_we_i = 1'b0;
  endtask

  task automatic write_tab(input int addr, input int data);
    cfg_we_i   = 1'b1;
    cfg_addr_i = AW'(addr);
    cfg_data_i = W'(data);
    tick();
  endtask

  task automatic start_run(input int len, input bit lp);
    st_rel.delete(); st_n.delete(); st_slot.delete();
    done_rel = -1; err_rel = -1;
    foreach (busy_at[i]) busy_at[i] = 1'b0;
    t0 = cyc;
    run_i = 1'b1;
    cfg_len_i = (AW+1)'(len);
    loop_i = lp;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_start"}, 32'(timer_start_o), 32'd0);
    chk({tag, "_n"},     32'(timer_n_o),     32'd0);
    chk({tag, "_slot"},  32'(slot_o),        32'd0);
    chk({tag, "_busy"},  32'(busy_o),        32'd0);
    chk({tag, "_done"},  32'(done_o),        32'd0);
    chk({tag, "_err"},   32'(err_o),         32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    cfg_len_i = 3'd1; loop_i = 1'b0; run_i = 1'b0; abort_i = 1'b0; timer_end_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // single slot
    write_tab(0, 3);
    start_run(1, 1'b0);
    repeat (8) tick();
    chk("a_nstarts", 32'(st_rel.size()), 32'd1);
    chk("a_start_cyc", 32'(qget(st_rel, 0)), 32'd1);
    chk("a_n", 32'(qget(st_n, 0)), 32'd3);
    chk("a_done_cyc", 32'(done_rel), 32'd6);
    chk("a_busy5", 32'(busy_at[5]), 32'd1);
    chk("a_busy6", 32'(busy_at[6]), 32'd0);

    // three slots {2,5,1}
    write_tab(0, 2); write_tab(1, 5); write_tab(2, 1);
    start_run(3, 1'b0);
    repeat (17) tick();
    chk("b_nstarts", 32'(st_rel.size()), 32'd3);
    chk("b_start1", 32'(qget(st_rel, 1)), 32'd5);
    chk("b_start2", 32'(qget(st_rel, 2)), 32'd12);
    chk("b_n1", 32'(qget(st_n, 1)), 32'd5);
    chk("b_n2", 32'(qget(st_n, 2)), 32'd1);
    chk("b_slot2", 32'(qget(st_slot, 2)), 32'd2);
    chk("b_done_cyc", 32'(done_rel), 32'd15);

    // loop {2,2}, drop loop_i before the second slot-1 end
    write_tab(0, 2); write_tab(1, 2);
    start_run(2, 1'b1);
    repeat (10) tick();
    loop_i = 1'b0;
    repeat (10) tick();
    chk("c_nstarts", 32'(st_rel.size()), 32'd4);
    chk("c_start3", 32'(qget(st_rel, 3)), 32'd13);
    chk("c_slot2", 32'(qget(st_slot, 2)), 32'd0);
    chk("c_slot3", 32'(qget(st_slot, 3)), 32'd1);
    chk("c_done_cyc", 32'(done_rel), 32'd17);

    // abort mid-interval {10}
    write_tab(0, 10);
    start_run(1, 1'b0);
    repeat (4) tick();
    abort_i = 1'b1;
    repeat (12) tick();
    chk("d_nstarts", 32'(st_rel.size()), 32'd1);
    chk("d_busy12", 32'(busy_at[12]), 32'd1);
    chk("d_busy13", 32'(busy_at[13]), 32'd0);
    chk("d_done", 32'(done_rel), 32'hFFFF_FFFF);

    // abort coincident with the end pulse
    write_tab(0, 3);
    start_run(1, 1'b0);
    repeat (5) tick();
    abort_i = 1'b1;
    repeat (4) tick();
    chk("e_busy5", 32'(busy_at[5]), 32'd1);
    chk("e_busy6", 32'(busy_at[6]), 32'd0);
    chk("e_done", 32'(done_rel), 32'hFFFF_FFFF);

    // zero entry in slot 1
    write_tab(0, 2); write_tab(1, 0);
    start_run(2, 1'b0);
    repeat (8) tick();
    chk("f_nstarts", 32'(st_rel.size()), 32'd1);
    chk("f_err_cyc", 32'(err_rel), 32'd5);
    chk("f_busy5", 32'(busy_at[5]), 32'd0);

    // len = 0
    start_run(0, 1'b0);
    repeat (3) tick();
    chk("g_nstarts", 32'(st_rel.size()), 32'd0);
    chk("g_err_cyc", 32'(err_rel), 32'd1);

    // valid run clears err; run while busy ignored; write to running slot held off
    start_run(1, 1'b0);
    repeat (2) tick();
    run_i = 1'b1; cfg_len_i = 3'd1;
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 16'd7;
    repeat (5) tick();
    chk("h_err", 32'(err_rel), 32'hFFFF_FFFF);
    chk("h_nstarts", 32'(st_rel.size()), 32'd1);
    chk("h_n", 32'(qget(st_n, 0)), 32'd2);
    chk("h_done_cyc", 32'(done_rel), 32'd5);

    // reset in the middle of WAIT, then a normal run
    write_tab(0, 9);
    start_run(1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    model_reset();
    end_at = -1;
    timer_end_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    write_tab(0, 4);
    start_run(1, 1'b0);
    repeat (9) tick();
    chk("i_start_cyc", 32'(qget(st_rel, 0)), 32'd1);
    chk("i_n", 32'(qget(st_n, 0)), 32'd4);
    chk("i_done_cyc", 32'(done_rel), 32'd7);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we_i   = 1'b1;
        cfg_addr_i = AW'($urandom_range(0, DEPTH - 1));
        cfg_data_i = W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) begin
        run_i     = 1'b1;
        cfg_len_i = (AW+1)'($urandom_range(0, 5));
      end
      abort_i = ($urandom_range(0, 39) == 0);
      loop_i  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Upstream sequencer for the `Timer` block. It holds a small programmable table of interval lengths and plays them back in order. For each interval it issues a one-cycle `start` and a stable `n` to the timer, then waits for the timer's end pulse before moving to the next slot. It supports one-shot and looping playback, abort, and error flagging of illegal table contents.

## Interface
Parameters:
- DEPTH, 4, number of interval slots (power of 2, ≥2)
- W, 16, interval width; must match the timer's `n_i` width
- AW, $clog2(DEPTH), slot index width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we_i  in  1  table write strobe
- cfg_addr_i  in  AW  table write slot
- cfg_data_i  in  W  table write value
- cfg_len_i  in  AW+1  number of active slots (1..DEPTH); sampled on run acceptance
- loop_i  in  1  1 = restart at slot 0 after the last slot; sampled at each final end
- run_i  in  1  start playback; accepted only in IDLE
- abort_i  in  1  stop playback after the current interval
- timer_end_i  in  1  timer `curr_end_q`
- timer_start_o  out  1  one-cycle start to the timer (`start_i`)
- timer_n_o  out  W  interval to the timer (`n_i`); held stable for the whole interval
- slot_o  out  AW  index of the slot currently running
- busy_o  out  1  high while in WAIT or ABORT
- done_o  out  1  one-cycle pulse when a non-loop sequence completes
- err_o  out  1  sticky error; cleared on the next accepted run_i

## Operation
- Table: DEPTH×W registers.
  - Reset value is 0.
  - Writable at any time.
  - A write to the running slot does not change timer_n_o until that slot is next launched.
- States:
  - IDLE: no playback.
  - WAIT: an interval is running; waiting for timer_end_i.
  - ABORT: abort requested; waiting for the timer to finish.
- Launch(s) is the action taken on a clock edge:
  - slot_o <= s.
  - timer_n_o <= table[s].
  - timer_start_o <= 1 for exactly one cycle.
  - state <= WAIT.
  - If table[s] == 0, launch instead sets err_o <= 1 and state <= IDLE, and issues no start. A zero interval would make the timer run 65536 cycles.
- IDLE:
  - On run_i: err_o <= 0 and len_q <= cfg_len_i.
  - If cfg_len_i == 0 or cfg_len_i > DEPTH: err_o <= 1 and stay in IDLE.
  - Otherwise: Launch(0).
  - abort_i is ignored in IDLE.
- WAIT:
  - abort_i without timer_end_i: go to ABORT.
  - timer_end_i with abort_i in the same cycle: abort wins. Go to IDLE with no done_o and no launch.
  - timer_end_i with slot_o < len_q−1: Launch(slot_o+1).
  - timer_end_i with slot_o == len_q−1 and loop_i == 1: Launch(0).
  - timer_end_i with slot_o == len_q−1 and loop_i == 0: go to IDLE and assert done_o next cycle.
- ABORT: on timer_end_i, go to IDLE with no done_o. The timer has no abort input, so the scheduler must wait out the interval.
- run_i is ignored in WAIT and in ABORT.
- Slot index arithmetic is modulo DEPTH. len_q comparison is done at AW+1 bits.

## Timing
- All outputs are registered.
- Reset values:
  - timer_start_o = 0
  - timer_n_o = 0
  - slot_o = 0
  - busy_o = 0
  - done_o = 0
  - err_o = 0
  - state = IDLE
- The timer shares rst_n, so a reset mid-run returns both blocks to idle. No recovery handshake is needed.
- run_i sampled at cycle 0 → timer_start_o high in cycle 1.
- Timer behaviour (start_o at cycle c, interval n): the timer runs c+1..c+n, and timer_end_i is high in cycle c+n+1.
- The next launch puts timer_start_o high in cycle c+n+2, so the per-slot period is n+2 cycles.
- The timer is back in IDLE during its end cycle, so the start in cycle c+n+2 is always accepted.
- done_o is high in the cycle after the final timer_end_i is sampled.
- busy_o:
  - rises with the first timer_start_o;
  - falls in the same cycle done_o rises;
  - on abort, falls in the cycle after the end pulse.
- timer_n_o never changes while the timer is running. The timer compares `n_i` live.
- err_o rises in the cycle after the offending launch or run, and holds until the next accepted run_i.

## Test plan
- Single slot: table[0]=3, len=1, loop=0, run_i at cycle 0 → start_o and n_o=3 at cycle 1, timer_end_i at cycle 5, done_o at cycle 6, busy_o low from cycle 6.
- Three slots {2,5,1}, len=3 → start_o at cycles 1, 5, 12 with n_o = 2, 5, 1 and slot_o = 0, 1, 2. Last end at cycle 14, done_o at cycle 15.
- Loop: {2,2}, len=2, loop=1 → start_o every 4 cycles with slot_o 0,1,0,1,… and no done_o. Drop loop_i before the 2nd slot-1 end → done_o one cycle after that end.
- Abort: {10}, run at 0, abort_i at cycle 4 → no new start_o, busy_o high until end at cycle 12, busy_o low at 13, done_o never asserted. Abort coincident with end → IDLE, no done_o.
- Errors:
  - table[1]=0, len=2 → err_o rises the cycle after slot 0 ends, no second start_o, busy_o low.
  - len=0 → err_o with no start_o.
  - The next valid run_i clears err_o.
- Robustness:
  - run_i while busy is ignored.
  - A cfg write to the running slot leaves timer_n_o unchanged.
  - rst_n asserted mid-WAIT → all outputs 0 immediately; a subsequent run_i plays normally.
